// File: rtl/slave_top.sv
// slave_top: I2C target endpoint clocked from SCL. It matches a 7-bit address,
// stores written bytes in a small circular FIFO and returns them on reads.
// SDA is open-drain: the block only ever pulls low or releases the line.
module slave_top #(
    parameter logic [6:0] SLAVE_ADDR = 7'b1010101,
    parameter int         FIFO_DEPTH = 8
) (
    input  logic SCL,
    input  logic rstn,
    inout  wire  SDA
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        ADDR_ACK  = 3'd2,
        WR_DATA   = 3'd3,
        WR_ACK    = 3'd4,
        RD_DATA   = 3'd5,
        RD_ACK    = 3'd6,
        WAIT_STOP = 3'd7
    } state_t;

    state_t      state_r;
    logic        sda_r;
    logic        sda_f;
    logic        sda_oe_r;
    logic [2:0]  bit_cnt_r;
    logic [6:0]  shift_r;
    logic        addr_match_r;
    logic        rw_r;
    logic        wr_ack_r;
    logic [7:0]  mem_r [FIFO_DEPTH];
    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;

    logic        sda_in_s;
    logic        start_s;
    logic        stop_s;
    logic        full_s;
    logic        empty_s;
    logic        push_s;
    logic        pop_s;
    logic [7:0]  rx_byte_s;
    logic [7:0]  tx_byte_s;

    assign sda_in_s  = SDA;
    assign SDA       = sda_oe_r ? 1'b0 : 1'bz;

    // SDA differing between the rising-edge and falling-edge samples means it
    // moved while SCL was high, which only a START or STOP may do.
    assign start_s   = sda_r & ~sda_f;
    assign stop_s    = ~sda_r & sda_f;

    assign full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty_s   = (wr_ptr_r == rd_ptr_r);
    assign rx_byte_s = {shift_r, sda_in_s};

    // Byte presented on reads: FIFO head, or all ones (line released) when empty.
    always_comb begin
        tx_byte_s = 8'hFF;
        if (empty_s) begin
            tx_byte_s = 8'hFF;
        end else begin
            tx_byte_s = mem_r[rd_ptr_r[AW-1:0]];
        end
    end

    // FIFO push/pop strobes, only on the 8th bit of an uninterrupted byte.
    always_comb begin
        push_s = 1'b0;
        pop_s  = 1'b0;
        if (!rstn && !start_s && !stop_s && (bit_cnt_r == 3'd7)) begin
            push_s = (state_r == WR_DATA) && !full_s;
            pop_s  = (state_r == RD_DATA) && !empty_s;
        end else begin
            push_s = 1'b0;
            pop_s  = 1'b0;
        end
    end

    // Rising edge: sample SDA, advance the protocol state machine and pointers.
    always_ff @(posedge SCL) begin
        if (rstn) begin
            sda_r        <= 1'b1;
            state_r      <= IDLE;
            bit_cnt_r    <= 3'd0;
            shift_r      <= 7'd0;
            addr_match_r <= 1'b0;
            rw_r         <= 1'b0;
            wr_ack_r     <= 1'b0;
            wr_ptr_r     <= {(AW+1){1'b0}};
            rd_ptr_r     <= {(AW+1){1'b0}};
        end else begin
            sda_r <= sda_in_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            if (start_s) begin
                // This edge already carries the first address bit.
                state_r   <= ADDR;
                shift_r   <= {6'd0, sda_in_s};
                bit_cnt_r <= 3'd1;
            end else if (stop_s) begin
                state_r   <= IDLE;
                bit_cnt_r <= 3'd0;
            end else begin
                case (state_r)
                    ADDR: begin
                        shift_r   <= {shift_r[5:0], sda_in_s};
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            addr_match_r <= (shift_r == SLAVE_ADDR);
                            rw_r         <= sda_in_s;
                            state_r      <= ADDR_ACK;
                            bit_cnt_r    <= 3'd0;
                        end
                    end
                    ADDR_ACK: begin
                        bit_cnt_r <= 3'd0;
                        if (addr_match_r) begin
                            state_r <= rw_r ? RD_DATA : WR_DATA;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    WR_DATA: begin
                        shift_r   <= {shift_r[5:0], sda_in_s};
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            wr_ack_r  <= !full_s;
                            state_r   <= WR_ACK;
                            bit_cnt_r <= 3'd0;
                        end
                    end
                    WR_ACK: begin
                        state_r <= wr_ack_r ? WR_DATA : WAIT_STOP;
                    end
                    RD_DATA: begin
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            state_r   <= RD_ACK;
                            bit_cnt_r <= 3'd0;
                        end
                    end
                    RD_ACK: begin
                        state_r <= sda_in_s ? WAIT_STOP : RD_DATA;
                    end
                    IDLE, WAIT_STOP: begin
                        state_r <= state_r;
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

    // Rising edge: store a completed write byte into the FIFO array.
    always_ff @(posedge SCL) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= rx_byte_s;
        end
    end

    // Falling edge: capture SDA for START/STOP detection and update the pull-down.
    always_ff @(negedge SCL) begin
        if (rstn) begin
            sda_f    <= 1'b1;
            sda_oe_r <= 1'b0;
        end else begin
            sda_f <= sda_in_s;
            case (state_r)
                ADDR_ACK: sda_oe_r <= addr_match_r;
                WR_ACK:   sda_oe_r <= wr_ack_r;
                RD_DATA:  sda_oe_r <= ~tx_byte_s[3'd7 - bit_cnt_r];
                default:  sda_oe_r <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_slave_top.sv
// tb_slave_top: drives I2C master traffic on a free-running SCL and checks the
// bus level on every rising edge against a transaction-level target model
// (a byte queue plus "who should be talking" state), with literal spot checks.
module tb_slave_top;
    localparam logic [6:0] ADDR  = 7'b1010101;
    localparam int         DEPTH = 8;

    logic scl     = 1'b0;
    logic rstn    = 1'b1;
    logic m_low   = 1'b0;   // master pulling SDA low
    logic exp_low = 1'b0;   // model: target should be pulling SDA low this slot
    logic chk_en  = 1'b0;
    wire  sda;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] fifo_q[$];
    int         m_state = 0;   // 0: target ignoring, 1: accepting writes, 2: serving reads

    assign sda = m_low ? 1'b0 : 1'bz;
    pullup (sda);

    slave_top #(.SLAVE_ADDR(ADDR), .FIFO_DEPTH(DEPTH)) dut (
        .SCL  (scl),
        .rstn (rstn),
        .SDA  (sda)
    );

    always #5 scl = ~scl;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Every rising edge: the line must be the wired-AND of master and expected target drive.
    always @(posedge scl) begin
        #1;
        if (chk_en) begin
            n_chk++;
            if (sda !== ((m_low || exp_low) ? 1'b0 : 1'b1)) begin
                n_fail++;
                $display("FAIL bus_level t=%0t got=%b want=%b", $time, sda,
                         (m_low || exp_low) ? 1'b0 : 1'b1);
            end
        end
    end

    task automatic check8(input string name, input logic [7:0] got, input logic [7:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%02h want=%02h", name, got, want);
        end
    endtask

    // One bit slot: master level mb (1 = release), expected target level sb.
    task automatic slot(input logic mb, input logic sb, output logic line);
        m_low   = ~mb;
        exp_low = ~sb;
        @(posedge scl);
        #1;
        line = sda;
        @(negedge scl);
        #2;
    endtask

    task automatic bus_start();
        m_low   = 1'b0;
        exp_low = 1'b0;
        @(posedge scl);
        #2;
        m_low = 1'b1;
        @(negedge scl);
        #2;
        m_state = 0;
    endtask

    task automatic bus_stop();
        m_low   = 1'b1;
        exp_low = 1'b0;
        @(posedge scl);
        #2;
        m_low = 1'b0;
        @(negedge scl);
        #2;
        m_state = 0;
    endtask

    task automatic addr_phase(input logic [6:0] a, input logic rw, output logic line);
        logic [7:0] b;
        logic       d;
        logic       match;
        b     = {a, rw};
        match = (a == ADDR);
        bus_start();
        for (int i = 7; i >= 0; i--) slot(b[i], 1'b1, d);
        slot(1'b1, match ? 1'b0 : 1'b1, line);
        m_state = match ? (rw ? 2 : 1) : 0;
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic line);
        logic sb;
        logic d;
        sb = 1'b1;
        if (m_state == 1) begin
            if (fifo_q.size() < DEPTH) begin
                fifo_q.push_back(b);
                sb = 1'b0;
            end else begin
                sb      = 1'b1;
                m_state = 0;
            end
        end
        for (int i = 7; i >= 0; i--) slot(b[i], 1'b1, d);
        slot(1'b1, sb, line);
    endtask

    task automatic rd_byte(input logic mack, output logic [7:0] got);
        logic [7:0] e;
        logic       d;
        e = 8'hFF;
        if (m_state == 2 && fifo_q.size() != 0) e = fifo_q.pop_front();
        for (int i = 7; i >= 0; i--) begin
            slot(1'b1, e[i], d);
            got[i] = d;
        end
        slot(~mack, 1'b1, d);
        if (!mack) m_state = 0;
    endtask

    task automatic partial(input int n);
        logic d;
        for (int i = 0; i < n; i++) slot(1'($urandom_range(0, 1)), 1'b1, d);
    endtask

    initial begin
        logic       line;
        logic [7:0] got;
        int         acks;
        int         kind;
        int         n;
        logic [6:0] a;

        // Reset for two SCL periods, bus idle
        rstn = 1'b1;
        repeat (2) @(posedge scl);
        @(negedge scl);
        #2;
        rstn = 1'b0;
        fifo_q.delete();
        m_state = 0;
        chk_en  = 1'b1;
        repeat (2) slot(1'b1, 1'b1, line);

        // Write 0x00
        addr_phase(ADDR, 1'b0, line);
        check8("wr_addr_ack", {7'd0, line}, 8'h00);
        wr_byte(8'h00, line);
        check8("wr_data_ack", {7'd0, line}, 8'h00);
        bus_stop();

        // Address mismatch: no ACK, data ignored
        addr_phase(7'b0101010, 1'b0, line);
        check8("mis_addr_nack", {7'd0, line}, 8'h01);
        wr_byte(8'h55, line);
        check8("mis_data_ignored", {7'd0, line}, 8'h01);
        bus_stop();

        // FIFO holds exactly 0x00
        addr_phase(ADDR, 1'b1, line);
        check8("rd_addr_ack", {7'd0, line}, 8'h00);
        rd_byte(1'b0, got);
        check8("rd_single", got, 8'h00);
        bus_stop();

        // Round trip
        addr_phase(ADDR, 1'b0, line);
        wr_byte(8'hA5, line);
        wr_byte(8'h3C, line);
        bus_stop();
        addr_phase(ADDR, 1'b1, line);
        rd_byte(1'b1, got);
        check8("rt_byte0", got, 8'hA5);
        rd_byte(1'b0, got);
        check8("rt_byte1", got, 8'h3C);
        bus_stop();

        // Empty read returns 0xFF
        addr_phase(ADDR, 1'b1, line);
        rd_byte(1'b0, got);
        check8("rd_empty", got, 8'hFF);
        bus_stop();

        // Fill: 8 ACKs then NACK, later bytes ignored
        addr_phase(ADDR, 1'b0, line);
        acks = 0;
        for (int i = 0; i < 9; i++) begin
            wr_byte(8'h10 + 8'(i), line);
            if (!line) acks++;
        end
        check8("full_ack_count", 8'(acks), 8'd8);
        check8("full_ninth_nack", {7'd0, line}, 8'h01);
        wr_byte(8'hEE, line);
        check8("wait_stop_ignored", {7'd0, line}, 8'h01);
        bus_stop();
        addr_phase(ADDR, 1'b1, line);
        for (int i = 0; i < 8; i++) begin
            rd_byte((i < 7) ? 1'b1 : 1'b0, got);
            check8("full_readback", got, 8'h10 + 8'(i));
        end
        bus_stop();
        addr_phase(ADDR, 1'b1, line);
        rd_byte(1'b0, got);
        check8("drained_empty", got, 8'hFF);
        bus_stop();

        // Partial byte aborted by repeated START
        addr_phase(ADDR, 1'b0, line);
        partial(4);
        addr_phase(ADDR, 1'b0, line);
        check8("rstart_addr_ack", {7'd0, line}, 8'h00);
        wr_byte(8'h77, line);
        bus_stop();
        addr_phase(ADDR, 1'b1, line);
        rd_byte(1'b1, got);
        check8("abort_byte", got, 8'h77);
        rd_byte(1'b0, got);
        check8("abort_no_partial", got, 8'hFF);
        bus_stop();

        // Reset in the middle of a read of 0x12 (two leading zeros driven)
        addr_phase(ADDR, 1'b0, line);
        wr_byte(8'h12, line);
        wr_byte(8'h34, line);
        bus_stop();
        addr_phase(ADDR, 1'b1, line);
        slot(1'b1, 1'b0, line);
        rstn = 1'b1;
        slot(1'b1, 1'b0, line);
        slot(1'b1, 1'b1, line);
        check8("rst_release", {7'd0, line}, 8'h01);
        rstn = 1'b0;
        fifo_q.delete();
        m_state = 0;
        slot(1'b1, 1'b1, line);
        addr_phase(ADDR, 1'b1, line);
        rd_byte(1'b0, got);
        check8("rst_fifo_empty", got, 8'hFF);
        bus_stop();

        // Randomized traffic against the model
        for (int t = 0; t < 40; t++) begin
            kind = int'($urandom_range(0, 3));
            a    = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 127)) : ADDR;
            if (kind <= 1) begin
                addr_phase(a, 1'b0, line);
                n = int'($urandom_range(0, 4));
                for (int j = 0; j < n; j++) wr_byte(8'($urandom), line);
            end else if (kind == 2) begin
                addr_phase(a, 1'b1, line);
                n = int'($urandom_range(1, 4));
                for (int j = 0; j < n; j++) rd_byte((j < n - 1) ? 1'b1 : 1'b0, got);
            end else begin
                addr_phase(a, 1'b0, line);
                partial(int'($urandom_range(1, 7)));
                addr_phase(ADDR, 1'b0, line);
                wr_byte(8'($urandom), line);
            end
            bus_stop();
        end

        repeat (2) slot(1'b1, 1'b1, line);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
